// File: rtl/id_ex_stage_if.sv
// Decode-side inputs, MEM-side hazard inputs and execute-side outputs of the ID/EX stage.
// The slave modport is the stage itself; the master modport is whatever drives decode and observes execute.
interface id_ex_stage_if #(
  parameter int DW = 32,
  parameter int RW = 5,
  parameter int CW = 16
);
  logic          regdst_D, alusrc_D, memtoreg_D, regwrite_D, memwrite_D, memread_D, branch_D;
  logic [2:0]    alucontrol_D;
  logic [DW-1:0] rd1_D, rd2_D, signimm_D;
  logic [RW-1:0] rs_D, rt_D, rd_D;
  logic          memtoreg_M;
  logic [RW-1:0] writereg_M;

  logic          regdst_E, alusrc_E, memtoreg_E, regwrite_E, memread_E, memwrite_E;
  logic [2:0]    alucontrol_E;
  logic [DW-1:0] rd1_E, rd2_E, signimm_E;
  logic [RW-1:0] rs_E, rt_E, rd_E, writereg_E;
  logic          stall_F, stall_D, flush_E;
  logic [CW-1:0] stall_cnt;

  modport slave (
    input  regdst_D, alusrc_D, memtoreg_D, regwrite_D, memwrite_D, memread_D, branch_D,
    input  alucontrol_D, rd1_D, rd2_D, signimm_D, rs_D, rt_D, rd_D, memtoreg_M, writereg_M,
    output regdst_E, alusrc_E, memtoreg_E, regwrite_E, memread_E, memwrite_E,
    output alucontrol_E, rd1_E, rd2_E, signimm_E, rs_E, rt_E, rd_E, writereg_E,
    output stall_F, stall_D, flush_E, stall_cnt
  );

  modport master (
    output regdst_D, alusrc_D, memtoreg_D, regwrite_D, memwrite_D, memread_D, branch_D,
    output alucontrol_D, rd1_D, rd2_D, signimm_D, rs_D, rt_D, rd_D, memtoreg_M, writereg_M,
    input  regdst_E, alusrc_E, memtoreg_E, regwrite_E, memread_E, memwrite_E,
    input  alucontrol_E, rd1_E, rd2_E, signimm_E, rs_E, rt_E, rd_E, writereg_E,
    input  stall_F, stall_D, flush_E, stall_cnt
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use and branch-in-decode hazard detection.
// A hazard holds fetch/decode and loads an all-zero bubble into execute; stall cycles are counted.
module id_ex_stage #(
  parameter int DW = 32,
  parameter int RW = 5,
  parameter int CW = 16
) (
  input logic        clk,
  input logic        reset_n,
  id_ex_stage_if.slave bus
);
  localparam logic [DW-1:0] ZERO_DW  = {DW{1'b0}};
  localparam logic [RW-1:0] ZERO_RW  = {RW{1'b0}};
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

  logic          regdst_q, alusrc_q, memtoreg_q, regwrite_q, memread_q, memwrite_q;
  logic          regdst_d, alusrc_d, memtoreg_d, regwrite_d, memread_d, memwrite_d;
  logic [2:0]    alucontrol_q, alucontrol_d;
  logic [DW-1:0] rd1_q, rd2_q, signimm_q, rd1_d, rd2_d, signimm_d;
  logic [RW-1:0] rs_q, rt_q, rd_q, rs_d, rt_d, rd_d;
  logic [CW-1:0] stall_cnt_q, stall_cnt_d;

  logic [RW-1:0] writereg_s;
  logic          lwstall_s, e_hit_s, m_hit_s, branchstall_s, stall_s;

  // Register $0 is excluded as a hazard source since writes to it are discarded.
  assign writereg_s    = regdst_q ? rd_q : rt_q;
  assign lwstall_s     = memtoreg_q && (rt_q != ZERO_RW) &&
                         ((rt_q == bus.rs_D) || (rt_q == bus.rt_D));
  assign e_hit_s       = regwrite_q && (writereg_s != ZERO_RW) &&
                         ((writereg_s == bus.rs_D) || (writereg_s == bus.rt_D));
  assign m_hit_s       = bus.memtoreg_M && (bus.writereg_M != ZERO_RW) &&
                         ((bus.writereg_M == bus.rs_D) || (bus.writereg_M == bus.rt_D));
  assign branchstall_s = bus.branch_D && (e_hit_s || m_hit_s);
  assign stall_s       = lwstall_s || branchstall_s;

  // Next execute contents: decode fields normally, an all-zero bubble on a hazard.
  always_comb begin
    regdst_d = 1'b0; alusrc_d = 1'b0; memtoreg_d = 1'b0;
    regwrite_d = 1'b0; memread_d = 1'b0; memwrite_d = 1'b0;
    alucontrol_d = 3'b000;
    rd1_d = ZERO_DW; rd2_d = ZERO_DW; signimm_d = ZERO_DW;
    rs_d = ZERO_RW; rt_d = ZERO_RW; rd_d = ZERO_RW;
    if (!stall_s) begin
      regdst_d = bus.regdst_D; alusrc_d = bus.alusrc_D; memtoreg_d = bus.memtoreg_D;
      regwrite_d = bus.regwrite_D; memread_d = bus.memread_D; memwrite_d = bus.memwrite_D;
      alucontrol_d = bus.alucontrol_D;
      rd1_d = bus.rd1_D; rd2_d = bus.rd2_D; signimm_d = bus.signimm_D;
      rs_d = bus.rs_D; rt_d = bus.rt_D; rd_d = bus.rd_D;
    end else begin
      regdst_d = 1'b0;
    end
  end

  // Saturating stall counter next state.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_s && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // Pipeline register and counter update; reset wins over any stall.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      regdst_q <= 1'b0; alusrc_q <= 1'b0; memtoreg_q <= 1'b0;
      regwrite_q <= 1'b0; memread_q <= 1'b0; memwrite_q <= 1'b0;
      alucontrol_q <= 3'b000;
      rd1_q <= ZERO_DW; rd2_q <= ZERO_DW; signimm_q <= ZERO_DW;
      rs_q <= ZERO_RW; rt_q <= ZERO_RW; rd_q <= ZERO_RW;
      stall_cnt_q <= {CW{1'b0}};
    end else begin
      regdst_q <= regdst_d; alusrc_q <= alusrc_d; memtoreg_q <= memtoreg_d;
      regwrite_q <= regwrite_d; memread_q <= memread_d; memwrite_q <= memwrite_d;
      alucontrol_q <= alucontrol_d;
      rd1_q <= rd1_d; rd2_q <= rd2_d; signimm_q <= signimm_d;
      rs_q <= rs_d; rt_q <= rt_d; rd_q <= rd_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.regdst_E     = regdst_q;
  assign bus.alusrc_E     = alusrc_q;
  assign bus.memtoreg_E   = memtoreg_q;
  assign bus.regwrite_E   = regwrite_q;
  assign bus.memread_E    = memread_q;
  assign bus.memwrite_E   = memwrite_q;
  assign bus.alucontrol_E = alucontrol_q;
  assign bus.rd1_E        = rd1_q;
  assign bus.rd2_E        = rd2_q;
  assign bus.signimm_E    = signimm_q;
  assign bus.rs_E         = rs_q;
  assign bus.rt_E         = rt_q;
  assign bus.rd_E         = rd_q;
  assign bus.writereg_E   = writereg_s;
  assign bus.stall_F      = stall_s;
  assign bus.stall_D      = stall_s;
  assign bus.flush_E      = stall_s;
  assign bus.stall_cnt    = stall_cnt_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed hazard scenarios plus randomized decode traffic
// compared against a behavioural model of the execute-stage contents and stall counter.
module tb_id_ex_stage;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int checks = 0;
  int errors = 0;

  id_ex_stage_if bus ();
  id_ex_stage dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic        regdst, alusrc, memtoreg, regwrite, memread, memwrite;
    logic [2:0]  aluc;
    logic [31:0] rd1, rd2, simm;
    logic [4:0]  rs, rt, rd;
  } e_t;

  e_t          m;
  int unsigned mcnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic dep(input logic [4:0] r);
    return (r != 5'd0) && (r == bus.rs_D || r == bus.rt_D);
  endfunction

  function automatic logic model_stall();
    logic [4:0] wr;
    wr = m.regdst ? m.rd : m.rt;
    return (m.memtoreg && dep(m.rt)) ||
           (bus.branch_D && ((m.regwrite && dep(wr)) || (bus.memtoreg_M && dep(bus.writereg_M))));
  endfunction

  function automatic e_t zero_e();
    e_t z;
    z.regdst = 1'b0; z.alusrc = 1'b0; z.memtoreg = 1'b0; z.regwrite = 1'b0;
    z.memread = 1'b0; z.memwrite = 1'b0; z.aluc = 3'd0;
    z.rd1 = 32'd0; z.rd2 = 32'd0; z.simm = 32'd0;
    z.rs = 5'd0; z.rt = 5'd0; z.rd = 5'd0;
    return z;
  endfunction

  task automatic check_all();
    logic s;
    s = model_stall();
    chk("regdst_E", 32'(bus.regdst_E), 32'(m.regdst));
    chk("alusrc_E", 32'(bus.alusrc_E), 32'(m.alusrc));
    chk("memtoreg_E", 32'(bus.memtoreg_E), 32'(m.memtoreg));
    chk("regwrite_E", 32'(bus.regwrite_E), 32'(m.regwrite));
    chk("memread_E", 32'(bus.memread_E), 32'(m.memread));
    chk("memwrite_E", 32'(bus.memwrite_E), 32'(m.memwrite));
    chk("alucontrol_E", 32'(bus.alucontrol_E), 32'(m.aluc));
    chk("rd1_E", bus.rd1_E, m.rd1);
    chk("rd2_E", bus.rd2_E, m.rd2);
    chk("signimm_E", bus.signimm_E, m.simm);
    chk("rs_E", 32'(bus.rs_E), 32'(m.rs));
    chk("rt_E", 32'(bus.rt_E), 32'(m.rt));
    chk("rd_E", 32'(bus.rd_E), 32'(m.rd));
    chk("writereg_E", 32'(bus.writereg_E), 32'(m.regdst ? m.rd : m.rt));
    chk("stall_F", 32'(bus.stall_F), 32'(s));
    chk("stall_D", 32'(bus.stall_D), 32'(s));
    chk("flush_E", 32'(bus.flush_E), 32'(s));
    chk("stall_cnt", 32'(bus.stall_cnt), mcnt);
  endtask

  // One clock: optional full comparison at the negedge, then model advances with the DUT.
  task automatic cycle(input bit do_chk);
    e_t          nxt;
    int unsigned ncnt;
    logic        s;
    @(negedge clk);
    if (do_chk) check_all();
    s = model_stall();
    ncnt = mcnt;
    if (!reset_n) begin
      nxt = zero_e();
      ncnt = 0;
    end else if (s) begin
      nxt = zero_e();
      ncnt = (mcnt < 32'd65535) ? mcnt + 1 : 32'd65535;
    end else begin
      nxt.regdst = bus.regdst_D; nxt.alusrc = bus.alusrc_D; nxt.memtoreg = bus.memtoreg_D;
      nxt.regwrite = bus.regwrite_D; nxt.memread = bus.memread_D; nxt.memwrite = bus.memwrite_D;
      nxt.aluc = bus.alucontrol_D; nxt.rd1 = bus.rd1_D; nxt.rd2 = bus.rd2_D;
      nxt.simm = bus.signimm_D; nxt.rs = bus.rs_D; nxt.rt = bus.rt_D; nxt.rd = bus.rd_D;
    end
    @(posedge clk);
    #1;
    m = nxt;
    mcnt = ncnt;
  endtask

  task automatic clr_d();
    bus.regdst_D = 1'b0; bus.alusrc_D = 1'b0; bus.memtoreg_D = 1'b0; bus.regwrite_D = 1'b0;
    bus.memwrite_D = 1'b0; bus.memread_D = 1'b0; bus.branch_D = 1'b0; bus.alucontrol_D = 3'd0;
    bus.rd1_D = 32'd0; bus.rd2_D = 32'd0; bus.signimm_D = 32'd0;
    bus.rs_D = 5'd0; bus.rt_D = 5'd0; bus.rd_D = 5'd0;
    bus.memtoreg_M = 1'b0; bus.writereg_M = 5'd0;
  endtask

  task automatic do_reset();
    clr_d();
    reset_n = 1'b0;
    cycle(1'b1);
    reset_n = 1'b1;
  endtask

  task automatic rand_d();
    bus.regdst_D = 1'($urandom_range(0, 1)); bus.alusrc_D = 1'($urandom_range(0, 1));
    bus.memtoreg_D = 1'($urandom_range(0, 1)); bus.regwrite_D = 1'($urandom_range(0, 1));
    bus.memwrite_D = 1'($urandom_range(0, 1)); bus.memread_D = 1'($urandom_range(0, 1));
    bus.branch_D = 1'($urandom_range(0, 1)); bus.alucontrol_D = 3'($urandom_range(0, 7));
    bus.rd1_D = $urandom; bus.rd2_D = $urandom; bus.signimm_D = $urandom;
    bus.rs_D = 5'($urandom_range(0, 3)); bus.rt_D = 5'($urandom_range(0, 3));
    bus.rd_D = 5'($urandom_range(0, 3));
    bus.memtoreg_M = 1'($urandom_range(0, 1)); bus.writereg_M = 5'($urandom_range(0, 3));
  endtask

  initial begin
    m = zero_e();
    mcnt = 0;

    // Reset with all decode inputs high.
    clr_d();
    bus.regdst_D = 1'b1; bus.alusrc_D = 1'b1; bus.memtoreg_D = 1'b1; bus.regwrite_D = 1'b1;
    bus.memwrite_D = 1'b1; bus.memread_D = 1'b1; bus.branch_D = 1'b1; bus.alucontrol_D = 3'h7;
    bus.rd1_D = 32'hFFFF_FFFF; bus.rd2_D = 32'hFFFF_FFFF; bus.signimm_D = 32'hFFFF_FFFF;
    bus.rs_D = 5'h1F; bus.rt_D = 5'h1F; bus.rd_D = 5'h1F;
    reset_n = 1'b0;
    cycle(1'b0);
    cycle(1'b1);
    chk("rst_rd1_E", bus.rd1_E, 32'd0);
    chk("rst_regwrite_E", 32'(bus.regwrite_E), 32'd0);
    chk("rst_stall_cnt", 32'(bus.stall_cnt), 32'd0);
    reset_n = 1'b1;
    cycle(1'b1);
    chk("rel_rd1_E", bus.rd1_E, 32'hFFFF_FFFF);
    chk("rel_alucontrol_E", 32'(bus.alucontrol_E), 32'd7);

    // Pass-through.
    do_reset();
    bus.rd1_D = 32'h1234_5678; bus.signimm_D = 32'hFFFF_FFFC;
    bus.regwrite_D = 1'b1; bus.regdst_D = 1'b1; bus.rd_D = 5'd9;
    cycle(1'b1);
    chk("pt_rd1_E", bus.rd1_E, 32'h1234_5678);
    chk("pt_signimm_E", bus.signimm_E, 32'hFFFF_FFFC);
    chk("pt_writereg_E", 32'(bus.writereg_E), 32'd9);
    chk("pt_stall_F", 32'(bus.stall_F), 32'd0);

    // Load-use.
    do_reset();
    bus.memtoreg_D = 1'b1; bus.regwrite_D = 1'b1; bus.memread_D = 1'b1; bus.rt_D = 5'd8;
    cycle(1'b1);
    clr_d();
    bus.rs_D = 5'd8;
    #1;
    chk("lu_stall_F", 32'(bus.stall_F), 32'd1);
    chk("lu_stall_D", 32'(bus.stall_D), 32'd1);
    chk("lu_flush_E", 32'(bus.flush_E), 32'd1);
    cycle(1'b1);
    chk("lu_regwrite_E", 32'(bus.regwrite_E), 32'd0);
    chk("lu_memtoreg_E", 32'(bus.memtoreg_E), 32'd0);
    chk("lu_stall_cnt", 32'(bus.stall_cnt), 32'd1);

    // lw then dependent beq: E dependency, then MEM dependency.
    do_reset();
    bus.memtoreg_D = 1'b1; bus.regwrite_D = 1'b1; bus.rt_D = 5'd8;
    cycle(1'b1);
    clr_d();
    bus.branch_D = 1'b1; bus.rs_D = 5'd8;
    cycle(1'b1);
    bus.memtoreg_M = 1'b1; bus.writereg_M = 5'd8;
    #1;
    chk("lb_second_stall", 32'(bus.stall_F), 32'd1);
    cycle(1'b1);
    bus.memtoreg_M = 1'b0; bus.writereg_M = 5'd0;
    cycle(1'b1);
    chk("lb_stall_cnt", 32'(bus.stall_cnt), 32'd2);

    // ALU result then dependent beq: single stall.
    do_reset();
    bus.regwrite_D = 1'b1; bus.regdst_D = 1'b1; bus.rd_D = 5'd5;
    cycle(1'b1);
    clr_d();
    bus.branch_D = 1'b1; bus.rt_D = 5'd5;
    cycle(1'b1);
    cycle(1'b1);
    chk("ab_stall_cnt", 32'(bus.stall_cnt), 32'd1);

    // $0 is never a hazard.
    do_reset();
    bus.memtoreg_D = 1'b1; bus.rt_D = 5'd0;
    cycle(1'b1);
    clr_d();
    #1;
    chk("r0_stall_F", 32'(bus.stall_F), 32'd0);
    cycle(1'b1);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      rand_d();
      reset_n = ($urandom_range(0, 31) != 0);
      cycle(1'b1);
    end
    reset_n = 1'b1;

    // Saturation under a persistent MEM-stage branch hazard.
    do_reset();
    bus.branch_D = 1'b1; bus.rs_D = 5'd7; bus.memtoreg_M = 1'b1; bus.writereg_M = 5'd7;
    for (int i = 0; i < 65539; i++) cycle(1'b0);
    chk("sat_stall_cnt", 32'(bus.stall_cnt), 32'h0000_FFFF);
    cycle(1'b1);
    chk("sat_hold_cnt", 32'(bus.stall_cnt), 32'h0000_FFFF);

    // Reset in the middle of a stall.
    reset_n = 1'b0;
    cycle(1'b1);
    chk("mid_rst_cnt", 32'(bus.stall_cnt), 32'd0);
    chk("mid_rst_regwrite", 32'(bus.regwrite_E), 32'd0);
    reset_n = 1'b1;
    cycle(1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
